// File: rtl/dq_serdes_pkg.sv
// Shared constants for the burst data-path: direction encoding used by the queue
// stage and this block, FSM state encoding, and beat-counter width helper.
package dq_serdes_pkg;

  localparam logic SEL_WR = 1'b1;
  localparam logic SEL_RD = 1'b0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  function automatic int beat_w(input int bl);
    return (bl <= 2) ? 1 : $clog2(bl);
  endfunction

endpackage

// File: rtl/dq_serdes_beat_cnt.sv
// Beat counter for one burst: restarts at 0 on start, advances while running,
// and wraps back to 0 after the last beat so an idle block never reads as last.
module dq_serdes_beat_cnt #(
  parameter int BL = 2,
  parameter int BW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          run,
  output logic [BW-1:0] beat,
  output logic          last
);

  logic [BW-1:0] beat_reg;

  assign last = (beat_reg == BW'(BL - 1));
  assign beat = beat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_reg <= '0;
    end else if (start) begin
      beat_reg <= '0;
    end else if (run) begin
      beat_reg <= last ? '0 : beat_reg + BW'(1);
    end
  end

endmodule

// File: rtl/dq_serdes.sv
// Burst SerDes stage: serializes a host write word onto DQ or assembles a read
// word from DQ over BL beats; all outputs are registered.
module dq_serdes
  import dq_serdes_pkg::*;
#(
  parameter int DW = 8,
  parameter int BL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SerDes_en,
  input  logic             SerDes_sel,
  input  logic [DW*BL-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_pop,
  output logic             wr_underrun,
  input  logic [DW-1:0]    dq_in,
  output logic [DW-1:0]    dq_out,
  output logic             dq_oe,
  output logic [DW*BL-1:0] rd_data,
  output logic             rd_valid,
  output logic             collision,
  output logic             active
);

  localparam int BW = beat_w(BL);
  localparam int WW = DW * BL;

  logic [1:0]    state_reg, state_next;
  logic [BW-1:0] beat;
  logic          last;
  logic          busy;
  logic          accept;
  logic          accept_wr;

  logic [WW-1:0] shift_reg, shift_next;
  logic [WW-1:0] asm_reg, asm_next;
  logic [WW-1:0] wr_word;
  logic [DW-1:0] dq_out_reg, dq_out_next;
  logic          dq_oe_reg, dq_oe_next;
  logic [WW-1:0] rd_data_reg;
  logic          rd_valid_reg, rd_valid_next;
  logic          wr_pop_reg, wr_underrun_reg, collision_reg, active_reg;

  // A strobe is only taken when the bus frees up next cycle: idle or last beat.
  assign busy      = (state_reg != ST_IDLE);
  assign accept    = SerDes_en && (!busy || last);
  assign accept_wr = accept && (SerDes_sel == SEL_WR);
  assign wr_word   = wr_valid ? wr_data : '0;

  dq_serdes_beat_cnt #(
    .BL (BL),
    .BW (BW)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .run   (busy),
    .beat  (beat),
    .last  (last)
  );

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = (SerDes_sel == SEL_WR) ? ST_WR : ST_RD;
    end else if (busy && last) begin
      state_next = ST_IDLE;
    end
  end

  // Beat 0 goes straight to dq_out; the rest shifts down one beat per cycle.
  always_comb begin
    shift_next  = shift_reg;
    dq_out_next = '0;
    dq_oe_next  = 1'b0;
    if (accept_wr) begin
      dq_out_next = wr_word[DW-1:0];
      shift_next  = wr_word >> DW;
      dq_oe_next  = 1'b1;
    end else if (state_reg == ST_WR && !last) begin
      dq_out_next = shift_reg[DW-1:0];
      shift_next  = shift_reg >> DW;
      dq_oe_next  = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BL; gi++) begin : g_slot
      assign asm_next[gi*DW +: DW] =
        (state_reg == ST_RD && beat == BW'(gi)) ? dq_in : asm_reg[gi*DW +: DW];
    end
  endgenerate

  assign rd_valid_next = (state_reg == ST_RD) && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      shift_reg       <= '0;
      asm_reg         <= '0;
      dq_out_reg      <= '0;
      dq_oe_reg       <= 1'b0;
      rd_data_reg     <= '0;
      rd_valid_reg    <= 1'b0;
      wr_pop_reg      <= 1'b0;
      wr_underrun_reg <= 1'b0;
      collision_reg   <= 1'b0;
      active_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      asm_reg         <= asm_next;
      dq_out_reg      <= dq_out_next;
      dq_oe_reg       <= dq_oe_next;
      rd_valid_reg    <= rd_valid_next;
      wr_pop_reg      <= accept_wr && wr_valid;
      wr_underrun_reg <= accept_wr && !wr_valid;
      collision_reg   <= SerDes_en && busy && !last;
      active_reg      <= (state_next != ST_IDLE);
      if (rd_valid_next) begin
        rd_data_reg <= asm_next;
      end
    end
  end

  assign dq_out      = dq_out_reg;
  assign dq_oe       = dq_oe_reg;
  assign rd_data     = rd_data_reg;
  assign rd_valid    = rd_valid_reg;
  assign wr_pop      = wr_pop_reg;
  assign wr_underrun = wr_underrun_reg;
  assign collision   = collision_reg;
  assign active      = active_reg;

endmodule

// File: tb/tb_dq_serdes.sv
// Directed bench for dq_serdes: a BL=2 instance (a) and a BL=4 instance (b)
// share clock and reset; each step checks outputs 1 time unit after the edge.
module tb_dq_serdes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_a = 1'b0, sel_a = 1'b0, wr_valid_a = 1'b0;
  logic [15:0] wr_data_a = '0;
  logic [7:0]  dq_in_a = '0;
  logic        wr_pop_a, wr_underrun_a, dq_oe_a, rd_valid_a, collision_a, active_a;
  logic [7:0]  dq_out_a;
  logic [15:0] rd_data_a;

  logic        en_b = 1'b0, sel_b = 1'b0, wr_valid_b = 1'b0;
  logic [31:0] wr_data_b = '0;
  logic [7:0]  dq_in_b = '0;
  logic        wr_pop_b, wr_underrun_b, dq_oe_b, rd_valid_b, collision_b, active_b;
  logic [7:0]  dq_out_b;
  logic [31:0] rd_data_b;

  int n_cmp = 0;
  int n_err = 0;

  dq_serdes #(.DW(8), .BL(2)) u_dut_a (
    .clk(clk), .rst(rst), .SerDes_en(en_a), .SerDes_sel(sel_a),
    .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_pop(wr_pop_a),
    .wr_underrun(wr_underrun_a), .dq_in(dq_in_a), .dq_out(dq_out_a),
    .dq_oe(dq_oe_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .collision(collision_a), .active(active_a)
  );

  dq_serdes #(.DW(8), .BL(4)) u_dut_b (
    .clk(clk), .rst(rst), .SerDes_en(en_b), .SerDes_sel(sel_b),
    .wr_data(wr_data_b), .wr_valid(wr_valid_b), .wr_pop(wr_pop_b),
    .wr_underrun(wr_underrun_b), .dq_in(dq_in_b), .dq_out(dq_out_b),
    .dq_oe(dq_oe_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .collision(collision_b), .active(active_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-22s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] rd_beats [4];

    // Reset state
    step(); step();
    chk("rst_dq_out_a", 32'(dq_out_a), 32'h0);
    chk("rst_dq_oe_a", 32'(dq_oe_a), 32'h0);
    chk("rst_active_a", 32'(active_a), 32'h0);
    chk("rst_rd_data_b", rd_data_b, 32'h0);
    chk("rst_flags_b", {27'h0, rd_valid_b, wr_pop_b, wr_underrun_b, collision_b, active_b}, 32'h0);
    rst = 1'b0;
    step();

    // Single write, BL=2
    wr_data_a = 16'hBEEF; wr_valid_a = 1'b1; sel_a = 1'b1; en_a = 1'b1;
    step();
    en_a = 1'b0;
    chk("wr_b0_dq", 32'(dq_out_a), 32'hEF);
    chk("wr_b0_oe", 32'(dq_oe_a), 32'h1);
    chk("wr_b0_pop", 32'(wr_pop_a), 32'h1);
    chk("wr_b0_active", 32'(active_a), 32'h1);
    step();
    chk("wr_b1_dq", 32'(dq_out_a), 32'hBE);
    chk("wr_b1_oe", 32'(dq_oe_a), 32'h1);
    chk("wr_b1_pop", 32'(wr_pop_a), 32'h0);
    step();
    chk("wr_end_oe", 32'(dq_oe_a), 32'h0);
    chk("wr_end_dq", 32'(dq_out_a), 32'h0);
    chk("wr_end_active", 32'(active_a), 32'h0);

    // Single read, BL=4
    rd_beats[0] = 8'h11; rd_beats[1] = 8'h22; rd_beats[2] = 8'h33; rd_beats[3] = 8'h44;
    sel_b = 1'b0; en_b = 1'b1;
    step();
    en_b = 1'b0;
    chk("rd_oe", 32'(dq_oe_b), 32'h0);
    for (int i = 0; i < 4; i++) begin
      dq_in_b = rd_beats[i];
      chk($sformatf("rd_novalid_%0d", i), 32'(rd_valid_b), 32'h0);
      step();
    end
    chk("rd_valid", 32'(rd_valid_b), 32'h1);
    chk("rd_data", rd_data_b, 32'h44332211);
    dq_in_b = 8'h99;
    step();
    chk("rd_valid_pulse", 32'(rd_valid_b), 32'h0);
    chk("rd_data_hold", rd_data_b, 32'h44332211);
    chk("rd_end_active", 32'(active_b), 32'h0);

    // Back-to-back write then read, BL=2
    wr_data_a = 16'h1234; wr_valid_a = 1'b1; sel_a = 1'b1; en_a = 1'b1;
    step();
    en_a = 1'b0;
    chk("b2b_t1_dq", 32'(dq_out_a), 32'h34);
    chk("b2b_t1_oe", 32'(dq_oe_a), 32'h1);
    step();
    chk("b2b_t2_dq", 32'(dq_out_a), 32'h12);
    chk("b2b_t2_oe", 32'(dq_oe_a), 32'h1);
    sel_a = 1'b0; en_a = 1'b1;
    step();
    en_a = 1'b0;
    chk("b2b_t3_oe", 32'(dq_oe_a), 32'h0);
    chk("b2b_t3_dq", 32'(dq_out_a), 32'h0);
    chk("b2b_t3_active", 32'(active_a), 32'h1);
    chk("b2b_t3_coll", 32'(collision_a), 32'h0);
    dq_in_a = 8'hA1;
    step();
    dq_in_a = 8'hB2;
    chk("b2b_t4_novalid", 32'(rd_valid_a), 32'h0);
    step();
    dq_in_a = 8'h00;
    chk("b2b_t5_valid", 32'(rd_valid_a), 32'h1);
    chk("b2b_t5_data", 32'(rd_data_a), 32'hB2A1);
    step();

    // Collision, BL=4
    wr_data_b = 32'hDDCCBBAA; wr_valid_b = 1'b1; sel_b = 1'b1; en_b = 1'b1;
    step();
    chk("col_t1_coll", 32'(collision_b), 32'h0);
    chk("col_t1_dq", 32'(dq_out_b), 32'hAA);
    chk("col_t1_pop", 32'(wr_pop_b), 32'h1);
    step();
    en_b = 1'b0;
    chk("col_t2_coll", 32'(collision_b), 32'h1);
    chk("col_t2_dq", 32'(dq_out_b), 32'hBB);
    chk("col_t2_pop", 32'(wr_pop_b), 32'h0);
    step();
    chk("col_t3_coll", 32'(collision_b), 32'h0);
    chk("col_t3_dq", 32'(dq_out_b), 32'hCC);
    step();
    chk("col_t4_dq", 32'(dq_out_b), 32'hDD);
    chk("col_t4_oe", 32'(dq_oe_b), 32'h1);
    step();
    chk("col_t5_active", 32'(active_b), 32'h0);
    chk("col_t5_oe", 32'(dq_oe_b), 32'h0);

    // Underrun, BL=4
    wr_data_b = 32'hFFFFFFFF; wr_valid_b = 1'b0; sel_b = 1'b1; en_b = 1'b1;
    step();
    en_b = 1'b0;
    chk("udr_t1_flag", 32'(wr_underrun_b), 32'h1);
    chk("udr_t1_pop", 32'(wr_pop_b), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("udr_b%0d_dq", i), 32'(dq_out_b), 32'h0);
      chk($sformatf("udr_b%0d_oe", i), 32'(dq_oe_b), 32'h1);
      if (i == 1) chk("udr_t2_flag", 32'(wr_underrun_b), 32'h0);
      step();
    end
    chk("udr_end_oe", 32'(dq_oe_b), 32'h0);

    // Reset mid-read, BL=4; a strobe coincident with reset is lost
    sel_b = 1'b0; en_b = 1'b1;
    step();
    en_b = 1'b0;
    dq_in_b = 8'h55;
    step();
    dq_in_b = 8'h66;
    rst = 1'b1; en_b = 1'b1; sel_b = 1'b1; wr_valid_b = 1'b1;
    step();
    rst = 1'b0; en_b = 1'b0;
    chk("rstm_active", 32'(active_b), 32'h0);
    chk("rstm_oe", 32'(dq_oe_b), 32'h0);
    chk("rstm_pop", 32'(wr_pop_b), 32'h0);
    chk("rstm_rd_data", rd_data_b, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstm_novalid_%0d", i), 32'(rd_valid_b), 32'h0);
      step();
    end

    rd_beats[0] = 8'h01; rd_beats[1] = 8'h02; rd_beats[2] = 8'h03; rd_beats[3] = 8'h04;
    sel_b = 1'b0; en_b = 1'b1;
    step();
    en_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dq_in_b = rd_beats[i];
      step();
    end
    chk("fresh_rd_valid", 32'(rd_valid_b), 32'h1);
    chk("fresh_rd_data", rd_data_b, 32'h04030201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
